// File: rtl/eth_pkg.sv
// Shared constants and state encoding for the multi-slot Ethernet MAC
// destination filter.
package eth_pkg;

  localparam int         MAC_LEN    = 6;
  localparam logic [7:0] BCAST_BYTE = 8'hFF;

  localparam logic [1:0] MK_NONE  = 2'd0;
  localparam logic [1:0] MK_UCAST = 2'd1;
  localparam logic [1:0] MK_BCAST = 2'd2;
  localparam logic [1:0] MK_MCAST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_HOLD   = 2'd3
  } filt_state_e;

endpackage

// File: rtl/eth_mac_slot.sv
// One unicast address slot: six writable address bytes plus a running
// match bit that is restarted on byte 0 and ANDed on every later byte.
module eth_mac_slot
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_byte,
  input  logic [7:0] wr_data,
  input  logic       cmp_start,
  input  logic       cmp_step,
  input  logic [2:0] cmp_byte,
  input  logic [7:0] cmp_data,
  output logic       match
);

  logic [7:0] addr_q [MAC_LEN];
  logic [7:0] sel_byte;
  logic       byte_eq;
  logic       match_q, match_d;

  always_comb begin
    sel_byte = 8'h00;
    for (int b = 0; b < MAC_LEN; b++) begin
      if (cmp_byte == 3'(b)) sel_byte = addr_q[b];
    end
  end

  assign byte_eq = (sel_byte == cmp_data);

  always_comb begin
    match_d = match_q;
    if (cmp_start)     match_d = byte_eq;
    else if (cmp_step) match_d = match_q & byte_eq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b0;
      for (int b = 0; b < MAC_LEN; b++) addr_q[b] <= 8'h00;
    end else begin
      match_q <= match_d;
      for (int b = 0; b < MAC_LEN; b++) begin
        if (wr_en && (wr_byte == 3'(b))) addr_q[b] <= wr_data;
      end
    end
  end

  assign match = match_q;

endmodule

// File: rtl/eth_mac_filter_multi.sv
// Destination-MAC filter: NUM_SLOTS unicast slots plus broadcast, multicast
// and promiscuous modes; inhibits rejected frames and counts drops.
//   state  | meaning
//   IDLE   | waiting for byte 0 of a frame; config writes allowed
//   ADDR   | collecting destination bytes 1..5
//   DECIDE | one-cycle decision, n_inhibit asserted here if rejected
//   HOLD   | waiting for frame_active low
module eth_mac_filter_multi
  import eth_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_active,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_slot,
  input  logic [2:0]           cfg_byte,
  input  logic [7:0]           cfg_data,
  input  logic [NUM_SLOTS-1:0] slot_en,
  input  logic                 bcast_en,
  input  logic                 mcast_en,
  input  logic                 promisc,
  output logic                 cfg_busy,
  output logic                 decision_valid,
  output logic                 accept,
  output logic [1:0]           match_kind,
  output logic [2:0]           match_slot,
  output logic                 n_inhibit,
  output logic [CNT_WIDTH-1:0] drop_count
);

  filt_state_e          state_q, state_d;
  logic [2:0]           byte_cnt_q, byte_cnt_d;
  logic                 bcast_q, bcast_d;
  logic                 mcast_q, mcast_d;
  logic                 accept_q, accept_d;
  logic [1:0]           kind_q, kind_d;
  logic [2:0]           slot_q, slot_d;
  logic                 rej_q, rej_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;

  logic                 take_byte, cmp_start, cmp_step;
  logic [2:0]           cmp_byte;
  logic [NUM_SLOTS-1:0] slot_match, slot_wr_en;
  logic                 ucast_hit, dec_accept;
  logic [2:0]           ucast_slot, dec_slot;
  logic [1:0]           dec_kind;

  assign take_byte = frame_active && byte_valid;
  assign cmp_start = (state_q == ST_IDLE) && take_byte;
  assign cmp_step  = (state_q == ST_ADDR) && take_byte;
  assign cmp_byte  = cmp_start ? 3'd0 : byte_cnt_q;
  assign cfg_busy  = (state_q != ST_IDLE);

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    assign slot_wr_en[s] = cfg_we && !cfg_busy && (cfg_slot == 3'(s))
                           && (cfg_byte < 3'(MAC_LEN));
    eth_mac_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (slot_wr_en[s]),
      .wr_byte   (cfg_byte),
      .wr_data   (cfg_data),
      .cmp_start (cmp_start),
      .cmp_step  (cmp_step),
      .cmp_byte  (cmp_byte),
      .cmp_data  (byte_data),
      .match     (slot_match[s])
    );
  end

  // Walk downwards so the lowest enabled matching slot is the one kept.
  always_comb begin
    ucast_hit  = 1'b0;
    ucast_slot = 3'd0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (slot_en[s] && slot_match[s]) begin
        ucast_hit  = 1'b1;
        ucast_slot = 3'(s);
      end
    end
  end

  always_comb begin
    dec_kind = MK_NONE;
    dec_slot = 3'd0;
    if (promisc) begin
      dec_kind = MK_MCAST;
    end else if (ucast_hit) begin
      dec_kind = MK_UCAST;
      dec_slot = ucast_slot;
    end else if (bcast_q && bcast_en) begin
      dec_kind = MK_BCAST;
    end else if (mcast_q && mcast_en) begin
      dec_kind = MK_MCAST;
    end
  end

  assign dec_accept = (dec_kind != MK_NONE);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bcast_d    = bcast_q;
    mcast_d    = mcast_q;
    accept_d   = accept_q;
    kind_d     = kind_q;
    slot_d     = slot_q;
    rej_d      = rej_q;
    drop_d     = drop_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take_byte) begin
          state_d    = ST_ADDR;
          byte_cnt_d = 3'd1;
          bcast_d    = (byte_data == BCAST_BYTE);
          mcast_d    = byte_data[0];
        end
      end
      ST_ADDR: begin
        if (!frame_active) begin
          state_d = ST_IDLE;
        end else if (byte_valid) begin
          bcast_d    = bcast_q && (byte_data == BCAST_BYTE);
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'(MAC_LEN - 1)) state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        accept_d = dec_accept;
        kind_d   = dec_kind;
        slot_d   = dec_slot;
        rej_d    = !dec_accept;
        if (!dec_accept && (drop_q != {CNT_WIDTH{1'b1}})) drop_d = drop_q + 1'b1;
        state_d  = frame_active ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (!frame_active) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= 3'd0;
      bcast_q    <= 1'b0;
      mcast_q    <= 1'b0;
      accept_q   <= 1'b0;
      kind_q     <= MK_NONE;
      slot_q     <= 3'd0;
      rej_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bcast_q    <= bcast_d;
      mcast_q    <= mcast_d;
      accept_q   <= accept_d;
      kind_q     <= kind_d;
      slot_q     <= slot_d;
      rej_q      <= rej_d;
      drop_q     <= drop_d;
    end
  end

  // Decision fields are visible during the DECIDE cycle itself, then held.
  assign decision_valid = (state_q == ST_DECIDE);
  assign accept         = decision_valid ? dec_accept : accept_q;
  assign match_kind     = decision_valid ? dec_kind   : kind_q;
  assign match_slot     = decision_valid ? dec_slot   : slot_q;
  assign n_inhibit      = !((decision_valid && !dec_accept) ||
                            ((state_q == ST_HOLD) && frame_active && rej_q));
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_eth_mac_filter_multi.sv
// Randomised bench for eth_mac_filter_multi against a frame-level reference
// model; a second instance with a 2-bit drop counter exercises saturation.
module tb_eth_mac_filter_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_active, byte_valid;
  logic [7:0] byte_data;
  logic       cfg_we;
  logic [2:0] cfg_slot, cfg_byte;
  logic [7:0] cfg_data;
  logic [3:0] slot_en;
  logic       bcast_en, mcast_en, promisc;

  logic        cfg_busy, decision_valid, accept, n_inhibit;
  logic [1:0]  match_kind;
  logic [2:0]  match_slot;
  logic [15:0] drop_count;

  logic        cfg_busy2, decision_valid2, accept2, n_inhibit2;
  logic [1:0]  match_kind2;
  logic [2:0]  match_slot2;
  logic [1:0]  drop_count2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [47:0] tbl [8];
  int          exp_drop;
  logic        last_acc;
  logic [1:0]  last_kind;
  logic [2:0]  last_slot;

  eth_mac_filter_multi #(.NUM_SLOTS(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .frame_active(frame_active), .byte_valid(byte_valid),
    .byte_data(byte_data), .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_byte(cfg_byte),
    .cfg_data(cfg_data), .slot_en(slot_en), .bcast_en(bcast_en), .mcast_en(mcast_en),
    .promisc(promisc), .cfg_busy(cfg_busy), .decision_valid(decision_valid),
    .accept(accept), .match_kind(match_kind), .match_slot(match_slot),
    .n_inhibit(n_inhibit), .drop_count(drop_count)
  );

  eth_mac_filter_multi #(.NUM_SLOTS(4), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .frame_active(frame_active), .byte_valid(byte_valid),
    .byte_data(byte_data), .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_byte(cfg_byte),
    .cfg_data(cfg_data), .slot_en(slot_en), .bcast_en(bcast_en), .mcast_en(mcast_en),
    .promisc(promisc), .cfg_busy(cfg_busy2), .decision_valid(decision_valid2),
    .accept(accept2), .match_kind(match_kind2), .match_slot(match_slot2),
    .n_inhibit(n_inhibit2), .drop_count(drop_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int sat2(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) tbl[s] = 48'h0;
    exp_drop  = 0;
    last_acc  = 1'b0;
    last_kind = 2'd0;
    last_slot = 3'd0;
  endtask

  // Frame-level decision straight from the priority rules.
  task automatic model_decide(input logic [47:0] dst, output logic [1:0] k, output logic [2:0] sl);
    k  = 2'd0;
    sl = 3'd0;
    if (promisc) begin
      k = 2'd3;
      return;
    end
    for (int s = 0; s < 4; s++) begin
      if (slot_en[s] && (tbl[s] == dst)) begin
        k  = 2'd1;
        sl = 3'(s);
        return;
      end
    end
    if (bcast_en && (dst == 48'hFFFF_FFFF_FFFF)) k = 2'd2;
    else if (mcast_en && dst[40]) k = 2'd3;
  endtask

  task automatic cfg_write(input logic [2:0] s, input logic [2:0] b, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_slot = s;
    cfg_byte = b;
    cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if ((int'(s) < 4) && (int'(b) < 6)) tbl[s][47 - 8 * int'(b) -: 8] = d;
  endtask

  task automatic write_addr(input logic [2:0] s, input logic [47:0] a);
    for (int b = 0; b < 6; b++) cfg_write(s, 3'(b), a[47 - 8 * b -: 8]);
  endtask

  task automatic idle_gap(input int n);
    frame_active = 1'b0;
    for (int c = 0; c < n; c++) begin
      byte_valid = 1'($urandom_range(1));
      byte_data  = 8'($urandom);
      @(negedge clk);
      chk("gap_busy", 32'(cfg_busy), 32'd0);
    end
    byte_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [47:0] dst, input int nb, input bit cfg_mid, input bit gaps);
    logic [1:0] ek;
    logic [2:0] es;
    logic       ea;
    model_decide(dst, ek, es);
    ea = (ek != 2'd0);
    frame_active = 1'b1;
    for (int i = 0; i < nb; i++) begin
      if (gaps && ($urandom_range(3) == 0)) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(negedge clk);
        chk("gap_dv", 32'(decision_valid), 32'd0);
      end
      byte_valid = 1'b1;
      byte_data  = (i < 6) ? dst[47 - 8 * i -: 8] : 8'($urandom);
      if (cfg_mid && (i == 2)) begin
        cfg_we   = 1'b1;
        cfg_slot = 3'($urandom_range(3));
        cfg_byte = 3'($urandom_range(5));
        cfg_data = 8'($urandom);
      end
      @(negedge clk);
      cfg_we = 1'b0;
      if (i < 5) begin
        chk("addr_busy", 32'(cfg_busy), 32'd1);
        chk("addr_dv", 32'(decision_valid), 32'd0);
      end else if (i == 5) begin
        chk("dec_dv", 32'(decision_valid), 32'd1);
        chk("dec_accept", 32'(accept), 32'(ea));
        chk("dec_kind", 32'(match_kind), 32'(ek));
        chk("dec_slot", 32'(match_slot), 32'(es));
        chk("dec_ninh", 32'(n_inhibit), 32'(ea));
        chk("dec_dv2", 32'(decision_valid2), 32'd1);
        last_acc  = ea;
        last_kind = ek;
        last_slot = es;
        if (!ea) exp_drop++;
      end else begin
        chk("hold_ninh", 32'(n_inhibit), 32'(ea));
        chk("hold_dv", 32'(decision_valid), 32'd0);
      end
    end
    byte_valid   = 1'b0;
    frame_active = 1'b0;
    @(negedge clk);
    chk("end_ninh", 32'(n_inhibit), 32'd1);
    chk("end_busy", 32'(cfg_busy), 32'd0);
    chk("end_dv", 32'(decision_valid), 32'd0);
    chk("end_accept", 32'(accept), 32'(last_acc));
    chk("end_kind", 32'(match_kind), 32'(last_kind));
    chk("end_slot", 32'(match_slot), 32'(last_slot));
    chk("drop16", 32'(drop_count), 32'(exp_drop));
    chk("drop2", 32'(drop_count2), 32'(sat2(exp_drop)));
  endtask

  task automatic set_en(input logic [3:0] se, input logic b, input logic m, input logic p);
    slot_en  = se;
    bcast_en = b;
    mcast_en = m;
    promisc  = p;
  endtask

  initial begin
    logic [47:0] dst;
    int          r, nb;
    rst = 1'b1;
    frame_active = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    cfg_we = 1'b0;
    cfg_slot = 3'd0;
    cfg_byte = 3'd0;
    cfg_data = 8'h00;
    set_en(4'b0000, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ninh", 32'(n_inhibit), 32'd1);
    chk("rst_accept", 32'(accept), 32'd0);
    chk("rst_kind", 32'(match_kind), 32'd0);
    chk("rst_slot", 32'(match_slot), 32'd0);
    chk("rst_dv", 32'(decision_valid), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    write_addr(3'd0, 48'h02_11_22_33_44_55);
    set_en(4'b0001, 1'b0, 1'b0, 1'b0);
    run_frame(48'h02_11_22_33_44_55, 9, 1'b0, 1'b0);
    idle_gap(2);

    write_addr(3'd1, 48'h0A_0B_0C_0D_0E_0F);
    write_addr(3'd3, 48'h0A_0B_0C_0D_0E_0F);
    set_en(4'b1010, 1'b0, 1'b0, 1'b0);
    run_frame(48'h0A_0B_0C_0D_0E_0F, 8, 1'b0, 1'b0);
    idle_gap(1);
    set_en(4'b1000, 1'b0, 1'b0, 1'b0);
    run_frame(48'h0A_0B_0C_0D_0E_0F, 8, 1'b0, 1'b0);
    idle_gap(1);
    set_en(4'b0000, 1'b0, 1'b0, 1'b0);
    run_frame(48'h0A_0B_0C_0D_0E_0F, 10, 1'b0, 1'b0);
    idle_gap(1);

    set_en(4'b0000, 1'b1, 1'b0, 1'b0);
    run_frame(48'hFFFF_FFFF_FFFF, 7, 1'b0, 1'b0);
    idle_gap(1);
    set_en(4'b0000, 1'b0, 1'b0, 1'b0);
    run_frame(48'hFFFF_FFFF_FFFF, 7, 1'b0, 1'b0);
    idle_gap(1);

    set_en(4'b0000, 1'b0, 1'b1, 1'b0);
    run_frame(48'h01_00_5E_00_00_01, 8, 1'b0, 1'b0);
    idle_gap(1);
    write_addr(3'd2, 48'h01_00_5E_00_00_01);
    set_en(4'b0100, 1'b0, 1'b1, 1'b1);
    run_frame(48'h01_00_5E_00_00_01, 6, 1'b0, 1'b0);
    idle_gap(1);

    set_en(4'b0001, 1'b0, 1'b0, 1'b0);
    run_frame(48'h02_11_22_33_44_55, 4, 1'b0, 1'b0);
    idle_gap(1);
    run_frame(48'h77_66_55_44_33_22, 9, 1'b1, 1'b0);
    idle_gap(1);
    run_frame(48'h02_11_22_33_44_55, 8, 1'b0, 1'b0);
    idle_gap(1);

    set_en(4'b0000, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 5; f++) begin
      run_frame({8'h10, 40'($urandom)}, 7, 1'b0, 1'b0);
      idle_gap(1);
    end
    chk("sat_drop2", 32'(drop_count2), 32'd3);

    for (int f = 0; f < 60; f++) begin
      for (int w = $urandom_range(3); w > 0; w--)
        cfg_write(3'($urandom_range(7)), 3'($urandom_range(7)), 8'($urandom));
      set_en(4'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)),
             ($urandom_range(7) == 0));
      r = $urandom_range(5);
      if (r <= 1)      dst = tbl[$urandom_range(3)];
      else if (r == 2) dst = 48'hFFFF_FFFF_FFFF;
      else if (r == 3) dst = {7'($urandom), 1'b1, 40'($urandom)};
      else             dst = {8'($urandom), 40'($urandom)};
      nb = ($urandom_range(7) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 12));
      run_frame(dst, nb, ($urandom_range(3) == 0), 1'b1);
      idle_gap($urandom_range(1, 3));
    end

    set_en(4'b0000, 1'b0, 1'b0, 1'b0);
    frame_active = 1'b1;
    for (int i = 0; i < 8; i++) begin
      byte_valid = 1'b1;
      byte_data  = (i == 0) ? 8'h20 : 8'($urandom);
      @(negedge clk);
    end
    chk("hold_ninh_pre_rst", 32'(n_inhibit), 32'd0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_ninh", 32'(n_inhibit), 32'd1);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    chk("mid_rst_drop2", 32'(drop_count2), 32'd0);
    chk("mid_rst_busy", 32'(cfg_busy), 32'd0);
    chk("mid_rst_accept", 32'(accept), 32'd0);
    @(negedge clk);
    frame_active = 1'b0;
    byte_valid   = 1'b0;
    rst          = 1'b0;
    @(negedge clk);
    set_en(4'b0001, 1'b0, 1'b0, 1'b0);
    run_frame(48'h0, 7, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
